// File: rtl/dmem_responder.sv
// dmem_responder: target end of a load/store port. Accepts one request at a
// time, waits LATENCY cycles, then presents a back-pressurable response.
// Little-endian 32-bit words, byte-enable stores, index wraps modulo DEPTH.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses whose byte
// enables are not a naturally sized lane group at the addressed lane.
module dmem_responder #(
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int IW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  if (LATENCY < 1) begin : g_bad_latency
    $fatal(1, "dmem_responder: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [IW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic [IW-1:0] req_idx;
  logic [31:0]   merged;
  logic          accept;
  logic          commit;
  logic          legal;

  assign req_idx    = IW'(req_addr[31:2] % DEPTH);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = (state == IDLE) && req_valid;
  assign commit     = (state == WAIT) && (cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one transaction in flight, no request/response overlap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and registered response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt       <= CW'(LATENCY - 1);
        lat_we    <= req_we;
        lat_idx   <= req_idx;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) resp_rdata <= legal ? merged : '0;
    end
  end

  // Word after applying the latched store's enabled bytes (loads pass through).
  always_comb begin
    merged = mem[lat_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (lat_we && lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  // Memory array: not reset; store commits on the last WAIT edge only.
  always_ff @(posedge clk) begin
    if (commit && lat_we && legal) mem[lat_idx] <= merged;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic req_legal;
  logic lat_legal;

  // Legal iff be is a byte/half/word lane group and addr[1:0] names its lowest lane.
  always_comb begin
    req_legal = 1'b0;
    case (req_be)
      4'b0001, 4'b0011, 4'b1111: req_legal = (req_addr[1:0] == 2'd0);
      4'b0010:                   req_legal = (req_addr[1:0] == 2'd1);
      4'b0100, 4'b1100:          req_legal = (req_addr[1:0] == 2'd2);
      4'b1000:                   req_legal = (req_addr[1:0] == 2'd3);
      default:                   req_legal = 1'b0;
    endcase
  end

  // Legality captured at acceptance; error flag registered with the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_legal <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) lat_legal <= req_legal;
      if (commit) resp_err  <= ~lat_legal;
    end
  end

  assign legal = lat_legal;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign legal    = 1'b1;
  assign resp_err = 1'b0;
`endif

endmodule
